// File: rtl/axis_pkg.sv
// Shared definitions for the sequence-checking AXI-Stream sink.
// Holds the FSM state encoding and the default data/counter widths.
package axis_pkg;

  localparam int AXIS_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int PAT_WIDTH      = 8;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_t;

endpackage

// File: rtl/axis_seq_sink_if.sv
// AXI-Stream handshake bundle between an upstream source and the sequence sink.
// The master modport is the source side; the slave modport is the sink side.
interface axis_seq_sink_if
  import axis_pkg::*;
#(
  parameter int AXIS_WIDTH = AXIS_WIDTH_DEF
);

  logic                  s_axis_tvalid;
  logic [AXIS_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tready;

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    output s_axis_tready
  );

endinterface

// File: rtl/axis_ready_gen.sv
// Backpressure generator: an 8-bit stall pattern that rotates while enabled
// and produces the sink's tready.
module axis_ready_gen
  import axis_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic [PAT_WIDTH-1:0] i_stallMask,
  output logic                 o_tready
);

  logic [PAT_WIDTH-1:0] r_pat;

  // Pattern is reloaded whenever the sink is idle so a new run starts at bit 0.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_pat <= i_stallMask;
    end else begin
      r_pat <= {r_pat[0], r_pat[PAT_WIDTH-1:1]};
    end
  end

  assign o_tready = ~reset & i_en & ~i_clr & ~r_pat[0];

endmodule

// File: rtl/axis_seq_sink.sv
// AXI-Stream sink that checks incoming data forms an incrementing sequence,
// counting accepted beats and mismatches; resynchronises after each mismatch.
module axis_seq_sink
  import axis_pkg::*;
#(
  parameter int AXIS_WIDTH = AXIS_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PAT_WIDTH-1:0]  stall_mask,
  axis_seq_sink_if.slave        s_axis,
  output logic                  synced,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [AXIS_WIDTH-1:0] last_data
);

  state_t                r_state,     w_stateNext;
  logic                  r_synced,    w_syncedNext;
  logic [CNT_WIDTH-1:0]  r_beatCount, w_beatCountNext;
  logic [CNT_WIDTH-1:0]  r_errCount,  w_errCountNext;
  logic                  r_errFlag,   w_errFlagNext;
  logic [AXIS_WIDTH-1:0] r_lastData,  w_lastDataNext;
  logic [AXIS_WIDTH-1:0] r_expected,  w_expectedNext;

  logic w_tready;
  logic w_handshake;

  axis_ready_gen u_readyGen (
    .clk         (clk),
    .reset       (reset),
    .i_en        (en),
    .i_clr       (clr),
    .i_stallMask (stall_mask),
    .o_tready    (w_tready)
  );

  assign s_axis.s_axis_tready = w_tready;
  assign w_handshake          = s_axis.s_axis_tvalid & w_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SYNC;
      r_synced    <= 1'b0;
      r_beatCount <= '0;
      r_errCount  <= '0;
      r_errFlag   <= 1'b0;
      r_lastData  <= '0;
      r_expected  <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_synced    <= w_syncedNext;
      r_beatCount <= w_beatCountNext;
      r_errCount  <= w_errCountNext;
      r_errFlag   <= w_errFlagNext;
      r_lastData  <= w_lastDataNext;
      r_expected  <= w_expectedNext;
    end
  end

  // tready is already low during clr, so clr and a handshake never coincide.
  always_comb begin
    w_stateNext     = r_state;
    w_syncedNext    = r_synced;
    w_beatCountNext = r_beatCount;
    w_errCountNext  = r_errCount;
    w_errFlagNext   = r_errFlag;
    w_lastDataNext  = r_lastData;
    w_expectedNext  = r_expected;

    if (clr) begin
      w_stateNext     = SYNC;
      w_syncedNext    = 1'b0;
      w_beatCountNext = '0;
      w_errCountNext  = '0;
      w_errFlagNext   = 1'b0;
      w_lastDataNext  = '0;
    end else if (w_handshake) begin
      w_lastDataNext  = s_axis.s_axis_tdata;
      w_expectedNext  = s_axis.s_axis_tdata + AXIS_WIDTH'(1);
      w_beatCountNext = r_beatCount + CNT_WIDTH'(1);
      unique case (r_state)
        SYNC: begin
          w_syncedNext = 1'b1;
          w_stateNext  = CHECK;
        end
        CHECK: begin
          if (s_axis.s_axis_tdata != r_expected) begin
            w_errFlagNext  = 1'b1;
            w_errCountNext = (r_errCount == '1) ? r_errCount
                                                : r_errCount + CNT_WIDTH'(1);
          end
        end
        default: w_stateNext = SYNC;
      endcase
    end
  end

  assign synced     = r_synced;
  assign beat_count = r_beatCount;
  assign err_count  = r_errCount;
  assign err_flag   = r_errFlag;
  assign last_data  = r_lastData;

endmodule

// File: tb/tb_axis_seq_sink.sv
// Directed bench for axis_seq_sink: a 32-bit and an 8-bit instance share the
// same stimulus; expected values are hand-computed constants.
module tb_axis_seq_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        clr;
  logic [7:0]  stallMask;
  logic        tvalid;
  logic [31:0] tdata;

  logic        syncedW,    syncedN;
  logic [15:0] beatCountW, beatCountN;
  logic [15:0] errCountW,  errCountN;
  logic        errFlagW,   errFlagN;
  logic [31:0] lastDataW;
  logic [7:0]  lastDataN;

  int checkCount = 0;
  int errorCount = 0;

  axis_seq_sink_if #(.AXIS_WIDTH(32)) ifWide ();
  axis_seq_sink_if #(.AXIS_WIDTH(8))  ifNarrow ();

  assign ifWide.s_axis_tvalid   = tvalid;
  assign ifWide.s_axis_tdata    = tdata;
  assign ifNarrow.s_axis_tvalid = tvalid;
  assign ifNarrow.s_axis_tdata  = tdata[7:0];

  axis_seq_sink #(.AXIS_WIDTH(32), .CNT_WIDTH(16)) dutWide (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .stall_mask (stallMask),
    .s_axis     (ifWide.slave),
    .synced     (syncedW),
    .beat_count (beatCountW),
    .err_count  (errCountW),
    .err_flag   (errFlagW),
    .last_data  (lastDataW)
  );

  axis_seq_sink #(.AXIS_WIDTH(8), .CNT_WIDTH(16)) dutNarrow (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .stall_mask (stallMask),
    .s_axis     (ifNarrow.slave),
    .synced     (syncedN),
    .beat_count (beatCountN),
    .err_count  (errCountN),
    .err_flag   (errFlagN),
    .last_data  (lastDataN)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [31:0] data, output int cycles);
    logic accepted;
    accepted = 1'b0;
    cycles   = 0;
    tvalid   = 1'b1;
    tdata    = data;
    while (!accepted && cycles < 32) begin
      @(negedge clk);
      accepted = ifWide.s_axis_tready;
      @(posedge clk);
      #1;
      cycles++;
    end
    tvalid = 1'b0;
    if (!accepted) checkOutput("beatTimeout", 64'd0, 64'd1);
  endtask

  task automatic doReset(input logic [7:0] mask);
    reset     = 1'b1;
    en        = 1'b0;
    clr       = 1'b0;
    tvalid    = 1'b0;
    stallMask = mask;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] nextVal;

    tdata = '0;
    doReset(8'h00);
    checkOutput("rstSynced", syncedW, 0);
    checkOutput("rstBeat",   beatCountW, 0);
    checkOutput("rstErr",    errCountW, 0);
    checkOutput("rstFlag",   errFlagW, 0);
    checkOutput("rstLast",   lastDataW, 0);

    // Unstalled stream 5..14
    en = 1'b1;
    for (int d = 5; d <= 14; d++) begin
      applyStimulus(32'(d), cyc);
      checkOutput("contReadyCycles", cyc, 1);
    end
    checkOutput("contBeat",   beatCountW, 10);
    checkOutput("contErr",    errCountW, 0);
    checkOutput("contLast",   lastDataW, 14);
    checkOutput("contSynced", syncedW, 1);

    // Alternating backpressure, junk data while stalled
    doReset(8'hAA);
    en      = 1'b1;
    nextVal = 32'h20;
    for (int c = 0; c < 16; c++) begin
      tvalid = 1'b1;
      tdata  = (c % 2 == 0) ? nextVal : 32'hDEAD_0000 + 32'(c);
      @(negedge clk);
      checkOutput("altReady", ifWide.s_axis_tready, (c % 2 == 0) ? 1 : 0);
      @(posedge clk);
      #1;
      if (c % 2 == 0) nextVal = nextVal + 1;
    end
    tvalid = 1'b0;
    checkOutput("altBeat", beatCountW, 8);
    checkOutput("altErr",  errCountW, 0);
    checkOutput("altLast", lastDataW, 32'h27);

    // Sequence 1,2,3,7,8
    doReset(8'h00);
    en = 1'b1;
    applyStimulus(32'd1, cyc);
    applyStimulus(32'd2, cyc);
    applyStimulus(32'd3, cyc);
    checkOutput("gapErrBefore", errCountW, 0);
    applyStimulus(32'd7, cyc);
    checkOutput("gapErrAt7",  errCountW, 1);
    checkOutput("gapFlagAt7", errFlagW, 1);
    applyStimulus(32'd8, cyc);
    checkOutput("gapErrAt8",  errCountW, 1);
    checkOutput("gapBeat",    beatCountW, 5);
    checkOutput("gapLast",    lastDataW, 8);

    // Wrap at data width: narrow instance wraps, wide one does not
    doReset(8'h00);
    en = 1'b1;
    applyStimulus(32'h0000_00FE, cyc);
    applyStimulus(32'h0000_00FF, cyc);
    applyStimulus(32'h0000_0000, cyc);
    checkOutput("wrapNarrowErr",  errCountN, 0);
    checkOutput("wrapNarrowLast", lastDataN, 8'h00);
    checkOutput("wrapNarrowBeat", beatCountN, 3);
    checkOutput("wrapNarrowFlag", errFlagN, 0);
    checkOutput("wrapWideErr",    errCountW, 1);

    // Enable dropped mid-stream with tvalid held
    doReset(8'h00);
    en = 1'b1;
    applyStimulus(32'd10, cyc);
    applyStimulus(32'd11, cyc);
    en     = 1'b0;
    tvalid = 1'b1;
    tdata  = 32'd12;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("enOffReady", ifWide.s_axis_tready, 0);
      @(posedge clk);
      #1;
    end
    checkOutput("enOffBeat", beatCountW, 2);
    checkOutput("enOffLast", lastDataW, 11);
    en = 1'b1;
    applyStimulus(32'd12, cyc);
    checkOutput("enOnErr",  errCountW, 0);
    checkOutput("enOnBeat", beatCountW, 3);
    applyStimulus(32'd50, cyc);
    checkOutput("preClrErr",  errCountW, 1);
    checkOutput("preClrFlag", errFlagW, 1);

    // Clear with tvalid high
    clr    = 1'b1;
    tvalid = 1'b1;
    tdata  = 32'd77;
    @(negedge clk);
    checkOutput("clrReady", ifWide.s_axis_tready, 0);
    @(posedge clk);
    #1;
    clr    = 1'b0;
    tvalid = 1'b0;
    checkOutput("clrBeat",   beatCountW, 0);
    checkOutput("clrErr",    errCountW, 0);
    checkOutput("clrFlag",   errFlagW, 0);
    checkOutput("clrSynced", syncedW, 0);
    checkOutput("clrLast",   lastDataW, 0);
    applyStimulus(32'd100, cyc);
    checkOutput("postClrErr",    errCountW, 0);
    checkOutput("postClrSynced", syncedW, 1);
    checkOutput("postClrBeat",   beatCountW, 1);
    checkOutput("postClrLast",   lastDataW, 100);
    applyStimulus(32'd101, cyc);
    checkOutput("postClrErr2",  errCountW, 0);
    checkOutput("postClrBeat2", beatCountW, 2);

    // Reset mid-stream discards the in-flight beat
    en     = 1'b1;
    tvalid = 1'b1;
    tdata  = 32'd102;
    reset  = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady", ifWide.s_axis_tready, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    tvalid = 1'b0;
    checkOutput("midRstBeat",   beatCountW, 0);
    checkOutput("midRstSynced", syncedW, 0);
    checkOutput("midRstLast",   lastDataW, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/axis_seq_sink.md
AXIS_SEQ_SINK -- requirements
Module: axis_seq_sink

Interface
REQ-001 SHALL have parameter AXIS_WIDTH, default 32, the stream data width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the beat and error counters.
REQ-003 SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, which enables acceptance of beats.
REQ-006 SHALL have port clr, input, 1 bit, a synchronous clear of the counters and state.
REQ-007 SHALL have port stall_mask, input, 8 bits, the backpressure pattern (a 1 means stall that cycle).
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit, the upstream data-valid signal.
REQ-009 SHALL have port s_axis_tdata, input, AXIS_WIDTH bits, the upstream data.
REQ-010 SHALL have port s_axis_tready, output, 1 bit, the ready signal to upstream.
REQ-011 SHALL have port synced, output, 1 bit, set once a first beat has been captured.
REQ-012 SHALL have port beat_count, output, CNT_WIDTH bits, the number of beats accepted.
REQ-013 SHALL have port err_count, output, CNT_WIDTH bits, the number of sequence mismatches.
REQ-014 SHALL have port err_flag, output, 1 bit, a sticky flag set on any mismatch.
REQ-015 SHALL have port last_data, output, AXIS_WIDTH bits, the data of the most recently accepted beat.

Function
REQ-016 SHALL drive s_axis_tready combinationally as en & ~clr & ~pat[0], where pat is an internal 8-bit pattern register.
REQ-017 SHALL load pat from stall_mask while en=0, and rotate pat right by one bit every cycle while en=1.
REQ-018 SHALL define a handshake as s_axis_tvalid & s_axis_tready in the same cycle; only handshakes change state, counters or last_data.
REQ-019 SHALL implement a two-state FSM: SYNC (waiting for the first beat) and CHECK (comparing each beat against the expected value).
REQ-020 SHALL, on a handshake in SYNC, set last_data to tdata and expected to tdata+1, increment beat_count, set synced=1 and move to CHECK, with no error check on that beat.
REQ-021 SHALL, on a handshake in CHECK where tdata equals expected, set last_data to tdata, set expected to tdata+1 and increment beat_count.
REQ-022 SHALL, on a handshake in CHECK where tdata differs from expected, also increment err_count, set err_flag, and resynchronise by setting expected to tdata+1, staying in CHECK.
REQ-023 SHALL compute expected modulo 2^AXIS_WIDTH, so all-ones followed by zero is a match.
REQ-024 SHALL let beat_count wrap modulo 2^CNT_WIDTH.
REQ-025 SHALL saturate err_count at all-ones.
REQ-026 SHALL keep err_flag set until reset or clr.
REQ-027 SHALL update all outputs one clock after the handshake edge; the only combinational path is to s_axis_tready.
REQ-028 SHALL, when en=0, hold the FSM state, counters and expected value unchanged.
REQ-029 SHALL, when clr=1, force tready low, return to SYNC, and zero synced, beat_count, err_count, err_flag and last_data on the next edge.
REQ-030 SHALL tolerate tdata changing while tvalid=1 and tready=0, evaluating only the value present at the handshake.

Reset
REQ-031 SHALL, while reset=1, set state to SYNC, zero synced, beat_count, err_count, err_flag, last_data and expected, and load pat from stall_mask.
REQ-032 SHALL force s_axis_tready to 0 while reset=1.
REQ-033 SHALL give reset priority over clr, en and any handshake; a reset mid-stream discards the in-flight beat.

Structure
REQ-034 SHALL place the FSM state encoding (SYNC, CHECK) and the default widths in a shared package, axis_pkg.
REQ-035 SHALL implement the pattern register and tready logic as the sub-module axis_ready_gen, instantiated once.

Verification
REQ-036 SHALL cover: stall_mask=0x00, en=1, source sends 5..14 -> tready constantly 1; beat_count=10, err_count=0, last_data=14, synced=1.
REQ-037 SHALL cover: stall_mask=0xAA -> tready alternates 1,0 starting with pat[0]=0; 8 beats take 16 cycles; err_count=0.
REQ-038 SHALL cover: sequence 1,2,3,7,8 -> err_count=1 at beat 7, err_flag=1, beat 8 matches, beat_count=5.
REQ-039 SHALL cover: AXIS_WIDTH=8, sequence 0xFE,0xFF,0x00 -> err_count=0, last_data=0x00.
REQ-040 SHALL cover: en dropped mid-stream with tvalid held high -> tready=0 and no count change; on re-enable the next beat is checked against the held expected value.
REQ-041 SHALL cover: clr asserted together with tvalid=1 -> no handshake, counters zeroed, synced=0; the next beat, e.g. 100, is accepted without error in SYNC.
